// File: rtl/fp16_norm_round.sv
// rtl/fp16_norm_round.sv - 3-stage normalise / round-to-nearest-even / pack to IEEE-754 binary16
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        operand handshake
//   in_sign, in_exp, in_mant   sign, signed biased exponent (bias 15), raw 22-bit significand
//                              value = in_mant * 2^-20 * 2^(in_exp-15)
//   out_valid / out_ready      result handshake
//   out_result                 binary16 result
//   out_overflow, out_underflow, out_inexact   exception flags, qualified by out_valid
module fp16_norm_round #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [21:0]      in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_inexact
);

  // Two guard bits absorb +1 and -21 adjustments without wrapping.
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_INF = EW'(31);

  // Stage 1: captured operand
  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [21:0]      s1_mant;

  // Stage 2: normalised operand; bit 21 is implicit so only [20:0] is kept
  logic                 s2_valid;
  logic                 s2_sign;
  logic                 s2_zero;
  logic signed [EW-1:0] s2_exp;
  logic [20:0]          s2_mant;

  // Flow control: a stage may load when it is empty or draining this cycle.
  logic s1_ready, s2_ready, s3_ready;

  assign s3_ready = !out_valid || out_ready;
  assign s2_ready = !s2_valid || s3_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = !reset && s1_ready;

  // Normalisation: leading-zero count and left shift
  logic [4:0]           lz;
  logic [21:0]          norm_mant;
  logic signed [EW-1:0] norm_exp;

  always_comb begin
    lz = 5'd0;
    // Ascending scan: the highest set bit overwrites earlier hits.
    for (int i = 0; i < 22; i++) begin
      if (s1_mant[i]) lz = 5'(21 - i);
    end
  end

  assign norm_mant = s1_mant << lz;
  assign norm_exp  = $signed({{2{s1_exp[EXP_W-1]}}, s1_exp}) + E_ONE
                   - $signed({{(EW-5){1'b0}}, lz});

  // Rounding and packing
  logic                 guard, sticky, round_up, carry;
  logic [9:0]           rnd_frac;
  logic signed [EW-1:0] rnd_exp;
  logic [15:0]          res;
  logic                 res_ovf, res_unf, res_inx;

  assign guard    = s2_mant[10];
  assign sticky   = |s2_mant[9:0];
  assign round_up = guard && (sticky || s2_mant[11]);
  // Bit 21 is always 1 for a non-zero operand, so an all-ones fraction
  // rounding up is exactly the 11-bit carry-out case.
  assign carry    = round_up && (&s2_mant[20:11]);
  assign rnd_frac = s2_mant[20:11] + 10'(round_up);
  assign rnd_exp  = carry ? s2_exp + E_ONE : s2_exp;

  always_comb begin
    res     = {s2_sign, 15'd0};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_inx = 1'b0;
    if (!s2_zero) begin
      if (rnd_exp >= E_INF) begin
        res     = {s2_sign, 5'h1f, 10'd0};
        res_ovf = 1'b1;
        res_inx = 1'b1;
      end else if (rnd_exp < E_ONE) begin
        // No subnormals: anything below the normal range flushes to zero.
        res_unf = 1'b1;
        res_inx = 1'b1;
      end else begin
        res     = {s2_sign, rnd_exp[4:0], rnd_frac};
        res_inx = guard || sticky;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= 16'h0000;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      if (s1_ready) s1_valid  <= in_valid;
      if (s2_ready) s2_valid  <= s1_valid;
      if (s3_ready) out_valid <= s2_valid;
      if (s3_ready && s2_valid) begin
        out_result    <= res;
        out_overflow  <= res_ovf;
        out_underflow <= res_unf;
        out_inexact   <= res_inx;
      end
    end
  end

  // Datapath registers; qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign <= in_sign;
      s1_exp  <= in_exp;
      s1_mant <= in_mant;
    end
    if (s1_valid && s2_ready) begin
      s2_sign <= s1_sign;
      s2_exp  <= norm_exp;
      s2_mant <= norm_mant[20:0];
      s2_zero <= !norm_mant[21];
    end
  end

endmodule

// File: tb/tb_fp16_norm_round.sv
// tb/tb_fp16_norm_round.sv - scoreboard bench for fp16_norm_round
module tb_fp16_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [21:0] in_mant;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  fp16_norm_round #(.EXP_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  fl;   // {overflow, underflow, inexact}
    int          acc;  // edge number at which the operand was accepted
    bit          lat;  // check 3-edge latency
    bit          gap;  // check back-to-back with previous result
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic [2:0] f);
    exp_t x;
    x.res = r; x.fl = f; x.acc = 0; x.lat = 0; x.gap = 0;
    return x;
  endfunction

  // Reference: value = m * 2^(e-35); keep 11 significant bits, RNE on the rest.
  function automatic exp_t model(input bit s, input int e, input logic [21:0] m);
    int b, eb, sh;
    longint q, rem, half;
    bit inx;
    if (m == 0) return mk({s, 15'd0}, 3'b000);
    b = 0;
    while (b < 21 && (m >> (b + 1)) != 0) b++;
    eb  = b + e - 35 + 15;
    sh  = b - 10;
    inx = 0;
    if (sh > 0) begin
      q    = longint'(m) >> sh;
      rem  = longint'(m) & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
    end else begin
      q = longint'(m) << (-sh);
    end
    if (q == 2048) begin q = 1024; eb++; end
    if (eb >= 31) return mk({s, 15'h7C00}, 3'b101);
    if (eb <= 0)  return mk({s, 15'd0}, 3'b011);
    return mk({s, 5'(eb), 10'(q)}, {2'b00, inx});
  endfunction

  // Monitor: pops and compares on every output transfer; checks stall hold.
  logic [18:0] held;
  bit          held_v = 0;
  int          last_pop = 0;

  always @(negedge clk) begin
    exp_t x;
    #2;
    if (reset) begin
      held_v = 0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        x = sb.pop_front();
        chk("result", out_result, x.res);
        chk("flags", {out_overflow, out_underflow, out_inexact}, x.fl);
        if (x.lat) chk("latency", cyc - x.acc, 2);
        if (x.gap) chk("back_to_back", cyc - last_pop, 1);
      end
      last_pop = cyc;
      held_v = 0;
    end else if (out_valid) begin
      if (held_v) chk("stall_hold", {out_result, out_overflow, out_underflow, out_inexact}, held);
      held   = {out_result, out_overflow, out_underflow, out_inexact};
      held_v = 1;
    end else begin
      held_v = 0;
    end
  end

  task automatic send(input bit s, input int e, input logic [21:0] m,
                      input exp_t x, input bit lat, input bit gap);
    bit done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      in_valid = 1; in_sign = s; in_exp = 8'(e); in_mant = m;
      #1;
      if (in_ready) begin
        x.acc = cyc + 1; x.lat = lat; x.gap = gap;
        sb.push_back(x);
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic one(input bit s, input int e, input logic [21:0] m,
                     input logic [15:0] r, input logic [2:0] f);
    out_ready = 1;
    send(s, e, m, mk(r, f), 1, 0);
    idle();
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   have;
    bit   rs;
    int   re, sent, guard;
    logic [21:0] rm;

    reset = 1; in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0; out_ready = 0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 16'h0000);
    chk("reset_flags", {out_overflow, out_underflow, out_inexact}, 3'b000);
    chk("reset_in_ready", in_ready, 0);
    @(negedge clk); @(negedge clk);
    #3 reset = 0;
    #1 chk("in_ready_after_reset", in_ready, 1);

    // Basic, rounding, range
    one(0, 15, 22'h100000, 16'h3C00, 3'b000);
    one(0, 15, 22'h300000, 16'h4200, 3'b000);
    one(0, 15, 22'h200400, 16'h4000, 3'b001);
    one(0, 15, 22'h200C00, 16'h4002, 3'b001);
    one(0, 15, 22'h3FFC00, 16'h4400, 3'b001);
    one(0, 30, 22'h200000, 16'h7C00, 3'b101);
    one(1, 30, 22'h200000, 16'hFC00, 3'b101);
    one(0, -3, 22'h100000, 16'h0000, 3'b011);
    one(1, 15, 22'h000000, 16'h8000, 3'b000);

    // Backpressure: three fill the pipe, then in_ready must drop
    out_ready = 0;
    send(0, 15, 22'h123456, model(0, 15, 22'h123456), 0, 0);
    send(1, 16, 22'h2ABCDE, model(1, 16, 22'h2ABCDE), 0, 1);
    send(0, 10, 22'h0F0F0F, model(0, 10, 22'h0F0F0F), 0, 1);
    @(negedge clk);
    in_valid = 1; in_sign = 1; in_exp = 8'd20; in_mant = 22'h1FFFFF;
    #1 chk("bp_in_ready_low", in_ready, 0);
    @(negedge clk);
    #1 chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1;
    #1 chk("bp_in_ready_release", in_ready, 1);
    if (in_ready) begin
      exp_t x;
      x = model(1, 20, 22'h1FFFFF);
      x.acc = cyc + 1; x.gap = 1;
      sb.push_back(x);
    end
    send(0, 17, 22'h3C0001, model(0, 17, 22'h3C0001), 0, 1);
    idle();
    drain();

    // Reset with three operands in flight
    out_ready = 0;
    send(0, 15, 22'h111111, model(0, 15, 22'h111111), 0, 0);
    send(0, 15, 22'h222222, model(0, 15, 22'h222222), 0, 0);
    send(0, 15, 22'h333333, model(0, 15, 22'h333333), 0, 0);
    idle();
    #3 reset = 1;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_result", out_result, 16'h0000);
    chk("midreset_flags", {out_overflow, out_underflow, out_inexact}, 3'b000);
    chk("midreset_in_ready", in_ready, 0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    #3 reset = 0;
    out_ready = 1;
    #1 chk("in_ready_after_midreset", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 chk("no_stale_out_valid", out_valid, 0);
    end
    one(0, 14, 22'h180000, 16'h3A00, 3'b000);

    // Random traffic against the reference model
    have = 0; sent = 0; guard = 0;
    rs = 0; re = 0; rm = 0;
    while (sent < 10000 && guard < 60000) begin
      @(negedge clk);
      guard++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!have && $urandom_range(0, 9) < 7) begin
        have = 1;
        rs = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) re = int'($urandom_range(0, 40)) - 5;
        else                           re = int'($urandom_range(0, 255)) - 128;
        case ($urandom_range(0, 15))
          0:       rm = 22'd0;
          1, 2:    rm = 22'($urandom_range(1, 4095));
          3, 4, 5: rm = 22'($urandom);
          default: rm = 22'($urandom_range(22'h100000, 22'h3FFFFF));
        endcase
      end
      in_valid = have; in_sign = rs; in_exp = 8'(re); in_mant = rm;
      #1;
      if (in_valid && in_ready) begin
        exp_t x;
        x = model(rs, re, rm);
        x.acc = cyc + 1;
        sb.push_back(x);
        sent++;
        have = 0;
      end
    end
    chk("random_sent", sent, 10000);
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp16_norm_round.md
FP16_NORM_ROUND -- requirements
Module: fp16_norm_round

Interface
REQ-001 SHALL have parameter EXP_W, default 8, the width of the two's-complement input exponent.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream holds a valid operand.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts an operand this cycle.
REQ-006 SHALL have port in_sign, input, 1 bit: result sign.
REQ-007 SHALL have port in_exp, input, EXP_W bits: signed biased exponent, bias 15.
REQ-008 SHALL have port in_mant, input, 22 bits: unnormalised significand, value = in_mant * 2^-20 * 2^(in_exp-15); this is the raw product of two 11-bit significands.
REQ-009 SHALL have port out_valid, output, 1 bit: out_result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_result.
REQ-011 SHALL have port out_result, output, 16 bits: IEEE-754 binary16 result.
REQ-012 SHALL have ports out_overflow, out_underflow and out_inexact, outputs, 1 bit each: flags qualified by out_valid.

Function
REQ-013 SHALL transfer an operand only when in_valid and in_ready are both high at a rising edge; an output transfer occurs only when out_valid and out_ready are both high.
REQ-014 SHALL form a 3-stage pipeline:
- S1: capture the operand.
- S2: normalise.
- S3: round, pack and drive the output registers.
REQ-015 SHALL have a latency of 3 edges: an operand accepted at edge N gives out_valid high after edge N+2, provided no stall occurs.
REQ-016 SHALL advance each stage when the next stage is empty or is transferring in the same cycle; in_ready = S1 empty OR S1 advancing. Throughput is 1 per cycle when out_ready is held high.
REQ-017 SHALL, under stall, hold out_result and all flags stable while out_valid is high and out_ready is low, with no operand dropped or duplicated.
REQ-018 S2 SHALL compute lz, the 22-bit leading-zero count (0..21), then:
- left-shift the significand by lz so that bit 21 is 1;
- compute e = in_exp + 1 - lz using at least EXP_W+2 bits.
REQ-019 S3 SHALL round to nearest, ties to even:
- kept bits = [21:11];
- guard = bit 10;
- sticky = OR of bits [9:0];
- increment when guard AND (sticky OR kept[0]).
REQ-020 SHALL handle a rounding carry-out (kept becomes 0x800) by setting kept to 0x400 and incrementing e.
REQ-021 SHALL pack a normal result as {sign, e[4:0], kept[9:0]} when 1 <= e <= 30.
REQ-022 SHALL, when e >= 31, output sign|0x7C00 (infinity) with out_overflow=1 and out_inexact=1.
REQ-023 SHALL, when e <= 0 and in_mant != 0, flush to signed zero (sign<<15) with out_underflow=1 and out_inexact=1; subnormals are not produced.
REQ-024 SHALL, when in_mant == 0, output signed zero with all flags 0.
REQ-025 SHALL set out_inexact = guard OR sticky for normal results.
REQ-026 SHALL never produce NaN.

Reset
REQ-027 SHALL, on reset high, asynchronously clear all stage valid bits, out_valid, out_result (0x0000) and all three flags, independent of clk.
REQ-028 SHALL drive in_ready low while reset is high and high in the first cycle after reset deasserts.
REQ-029 SHALL discard all in-flight operands on reset mid-operation, with no out_valid pulse for them after release.

Verification
REQ-030 Basic: bench SHALL drive in_mant=0x100000, in_exp=15, sign=0 and check out_result=0x3C00 with no flags; then drive 0x300000, exp 15 and check 0x4200. Both results SHALL appear 3 edges after acceptance.
REQ-031 Rounding: bench SHALL check that 0x200400, exp 15 gives 0x4000 with inexact=1 (tie, even), that 0x200C00 gives 0x4002 (tie, round up), and that 0x3FFC00 gives 0x4400 (carry-out renormalisation).
REQ-032 Range: bench SHALL check that 0x200000, exp 30 gives 0x7C00 with overflow=1; that the same with sign=1 gives 0xFC00; that 0x100000, exp -3 gives 0x0000 with underflow=1; and that in_mant=0, sign=1 gives 0x8000 with no flags.
REQ-033 Backpressure: bench SHALL hold out_ready=0 while streaming 5 operands and check that in_ready drops after 3 accepted operands. After out_ready is raised, all accepted results SHALL emerge in order, unchanged, one per cycle.
REQ-034 Reset mid-stream: bench SHALL assert reset asynchronously between edges with 3 operands in flight and check that out_valid=0 immediately. After release, out_valid SHALL stay 0 until a new operand is accepted and fully processed.
REQ-035 Random: bench SHALL apply 10k random operands with random in_valid/out_ready and compare each result against a reference model of REQ-018..REQ-026, in order.
